// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: shares one combinational ALU between NUM_REQ requesters.
// Requesters are picked round-robin. The chosen operands are latched and driven
// to the ALU for one cycle. The ALU result is registered and held until the
// response is taken.
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   req_valid_i / req_ready_o  per-requester handshake (ready is a one-hot grant)
//   req_op_i/req_a_i/req_b_i   packed per-requester op and operands
//   alu_op_o/alu_a_o/alu_b_o   ALU drive, non-zero only during EXEC
//   alu_result_i/alu_zero_i    ALU combinational result and zero flag
//   rsp_*                      registered response, held until rsp_ready_i
//   busy_o                     high whenever the FSM is not idle
module alu_rr_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned OP_WIDTH   = 4,
   parameter int unsigned ID_WIDTH   = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid_i,
   output logic [NUM_REQ-1:0]             req_ready_o,
   input  logic [NUM_REQ*OP_WIDTH-1:0]    req_op_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_a_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_b_i,
   output logic [OP_WIDTH-1:0]            alu_op_o,
   output logic [DATA_WIDTH-1:0]          alu_a_o,
   output logic [DATA_WIDTH-1:0]          alu_b_o,
   input  logic [DATA_WIDTH-1:0]          alu_result_i,
   input  logic                           alu_zero_i,
   output logic                           rsp_valid_o,
   output logic [ID_WIDTH-1:0]            rsp_id_o,
   output logic [DATA_WIDTH-1:0]          rsp_result_o,
   output logic                           rsp_zero_o,
   input  logic                           rsp_ready_i,
   output logic                           busy_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]            state_q,  state_d;
   logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_WIDTH-1:0]   id_q,     id_d;
   logic [OP_WIDTH-1:0]   op_q,     op_d;
   logic [DATA_WIDTH-1:0] a_q,      a_d;
   logic [DATA_WIDTH-1:0] b_q,      b_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic                  zero_q,   zero_d;

   logic                  grant_found;
   logic [ID_WIDTH-1:0]   grant_idx;
   logic [ID_WIDTH-1:0]   cand_id;
   int unsigned           cand;

   // Round-robin search starting at rr_ptr, wrapping NUM_REQ-1 -> 0
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      cand_id     = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = 32'(rr_ptr_q) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         cand_id = ID_WIDTH'(cand);
         if (!grant_found && req_valid_i[cand_id]) begin
            grant_found = 1'b1;
            grant_idx   = cand_id;
         end
      end
   end

   // Grant is combinational; reset forces it low so reset shows all-zero outputs
   always_comb begin
      req_ready_o = '0;
      if (!reset && state_q == S_IDLE && grant_found)
         req_ready_o = NUM_REQ'(1) << grant_idx;
   end

   // Next-state and datapath register update
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      id_d     = id_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      zero_d   = zero_q;
      case (state_q)
         S_IDLE: begin
            if (grant_found) begin
               op_d    = req_op_i[grant_idx*OP_WIDTH +: OP_WIDTH];
               a_d     = req_a_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];
               b_d     = req_b_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];
               id_d    = grant_idx;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            result_d = alu_result_i;
            zero_d   = alu_zero_i;
            state_d  = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready_i) begin
               // Served requester drops to lowest priority
               rr_ptr_d = (id_q == ID_WIDTH'(NUM_REQ-1)) ? '0 : id_q + 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= '0;
         id_q     <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         id_q     <= id_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

   // ALU sees latched operands only during EXEC, zeros otherwise
   assign alu_op_o     = (state_q == S_EXEC) ? op_q : '0;
   assign alu_a_o      = (state_q == S_EXEC) ? a_q  : '0;
   assign alu_b_o      = (state_q == S_EXEC) ? b_q  : '0;
   assign rsp_valid_o  = (state_q == S_RESP);
   assign rsp_id_o     = id_q;
   assign rsp_result_o = result_q;
   assign rsp_zero_o   = zero_q;
   assign busy_o       = (state_q != S_IDLE);

endmodule
